// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared definitions for the pipeline flush / fetch redirect controller.
// Holds the controller state encoding and the default exception entry PC.
package flush_redirect_ctrl_pkg;

    localparam logic [31:0] EX_VECTOR_DEF = 32'hbfc00380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } frc_state_e;

endpackage

// File: rtl/flush_redirect_ctrl.sv
// Flushes the pipe on a WB exception/ERET, drains in-flight fetch responses, then offers the redirect PC.
// flush is same-cycle; redirect_valid follows after drain and holds until redirect_ready (no comb ready->valid path).
module flush_redirect_ctrl
    import flush_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEF,
    parameter int          CNT_W     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    input  logic        fs_req_fire,
    input  logic        fs_resp,
    output logic        flush,
    output logic        resp_discard,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    frc_state_e       state_q, state_d;
    logic [CNT_W-1:0] ost_q, ost_d;
    logic [CNT_W-1:0] dc_q, dc_d;
    logic [31:0]      tgt_q, tgt_d;
    logic             event_w;

    assign event_w = ws_ex | ws_eret;
    // Post-cycle outstanding count; also the discard count loaded on an event.
    assign ost_d   = ost_q + CNT_W'(fs_req_fire) - CNT_W'(fs_resp);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ost_q   <= '0;
            dc_q    <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            ost_q   <= ost_d;
            dc_q    <= dc_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dc_d           = dc_q;
        tgt_d          = tgt_q;
        flush          = 1'b0;
        resp_discard   = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (event_w) begin
                    flush   = 1'b1;
                    tgt_d   = ws_ex ? EX_VECTOR : cp0_epc;
                    dc_d    = ost_d;
                    state_d = (ost_d == '0) ? ST_REDIRECT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                resp_discard = fs_resp;
                dc_d         = dc_q + CNT_W'(fs_req_fire) - CNT_W'(fs_resp);
                if (dc_d == '0) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign redirect_pc = tgt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
